fact_arbiter: RTL and testbench
===============================

# fact_arbiter

Shares a single factorial unit (`fact`: go/in/Done/Error/result) among NREQ independent requesters. Requests are granted round-robin. The block drives the unit's go/in handshake and watches for completion or a hang with a watchdog. Each result and its error flag return to the requester that owns the job. It sits between the requester-side logic and one `fact` instance.

## Interface
- NREQ, 4: number of requesters (2..8)
- W_IN, 4: operand width, matches `fact` input
- W_RES, 32: result width, matches `fact` result
- TIMEOUT, 64: max cycles waiting for Done/Error before forced error

- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  request per requester; held high until its gnt pulse
- req_n  in  NREQ*W_IN  packed operands; requester i at [i*W_IN +: W_IN]
- gnt  out  NREQ  one-hot, one-cycle pulse when request accepted
- rsp_valid  out  NREQ  one-hot, one-cycle pulse when result ready for that requester
- rsp_result  out  W_RES  shared result bus, valid with rsp_valid, held until next response
- rsp_error  out  1  error flag qualified by rsp_valid, held like rsp_result
- busy  out  1  high in every state except IDLE
- fact_go  out  1  go to `fact`
- fact_in  out  W_IN  operand to `fact`
- fact_done  in  1  `fact` Done
- fact_error  in  1  `fact` Error
- fact_result  in  W_RES  `fact` result

## Operation
- All outputs are registered. On reset: gnt, rsp_valid, fact_go, busy, rsp_error = 0; rsp_result, fact_in = 0; state IDLE; rr pointer = NREQ-1, so requester 0 has highest priority first.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> DRAIN -> IDLE.
- IDLE: if any req bit is set, pick the first set bit searching from rr+1 upward, wrapping. Latch owner and its operand. Pulse gnt[owner]. Go to ISSUE.
- ISSUE: assert fact_go; fact_in = latched operand. Clear watchdog. Go to WAIT.
- WAIT: fact_go and fact_in are held stable. Watchdog increments each cycle.
  - fact_done or fact_error sampled high: latch fact_result; rsp_error = fact_error. Go to RESP.
  - Watchdog reaches TIMEOUT-1 with neither high: rsp_result = 0, rsp_error = 1. Go to RESP.
  - Done and Error both high together: treated as an error; result is still latched.
- RESP: pulse rsp_valid[owner]; deassert fact_go; rr = owner. Go to DRAIN.
- DRAIN: fact_go = 0. Stay until fact_done and fact_error are both low, then go to IDLE. There is no timeout in DRAIN.
- The arbiter never checks the operand range. Unit errors (e.g. n=0 or overflow) pass through on rsp_error.
- A req still high in IDLE after a response is treated as a new request. Requesters must drop req the cycle after gnt.
- Requests arriving in any state other than IDLE wait; no request is lost while req stays high.

## Timing
- Edge t samples req in IDLE. At t+1: gnt pulse and fact_go=1 (ISSUE); WAIT from t+2.
- If fact_done is first sampled high at edge d: rsp_valid at d+1. fact_go is low from d+1.
- Minimum gap between consecutive grants: 4 cycles after Done, plus any cycles fact_done stays high in DRAIN.
- Timeout: rsp_valid exactly TIMEOUT cycles after entering WAIT.
- rst high at any edge: the next cycle has reset values. No rsp_valid is issued for the aborted job. fact_go drops immediately.

## Test plan
- Single request: req[0], n=5, behavioural `fact` model. Expect one gnt[0] pulse, then fact_go with fact_in=5, then rsp_valid[0] with rsp_result=120 and rsp_error=0. busy low afterwards.
- Simultaneous requests after reset: req[3:0] with n=3,4,5,6. Expect grants in order 0,1,2,3 and responses 6, 24, 120, 720, each with only the owner's rsp_valid bit set.
- Fairness: req[0] and req[2] re-asserted continuously with n=4. Expect grants alternating 0,2,0,2 for 8 jobs; req[1] never granted.
- Error pass-through: n=0 and n=13 with the model raising Error. Expect rsp_error=1 to the owner and rsp_result equal to the model's value.
- Watchdog with TIMEOUT=64: model never raises Done. Expect rsp_valid with rsp_error=1 and rsp_result=0 exactly 64 cycles after WAIT entry, then return to IDLE.
- Reset mid-WAIT: assert rst for 1 cycle during n=10. Expect all outputs 0 the next cycle and no rsp_valid. A following req[1] with n=3 returns 6.

Source files
------------

// File: rtl/fact_arbiter.sv
`default_nettype none
// ============================================================================
// fact_arbiter : round-robin sharing of one factorial unit among NREQ
//                requesters, with a completion watchdog.
// Revision     : 1.0  initial release
// ============================================================================
module fact_arbiter #(
  parameter int NREQ    = 4,
  parameter int W_IN    = 4,
  parameter int W_RES   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*W_IN-1:0]   req_n,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [W_RES-1:0]       rsp_result,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   fact_go,
  output logic [W_IN-1:0]        fact_in,
  input  logic                   fact_done,
  input  logic                   fact_error,
  input  logic [W_RES-1:0]       fact_result
);

  localparam int c_iw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_ww = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_ww-1:0] c_wd_last = c_ww'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state, w_state;
  logic [c_iw-1:0]     r_rr, w_rr;
  logic [c_iw-1:0]     r_owner, w_owner;
  logic [c_ww-1:0]     r_wd, w_wd;
  logic [NREQ-1:0]     r_gnt, w_gnt;
  logic [NREQ-1:0]     r_rsp_valid, w_rsp_valid;
  logic [W_RES-1:0]    r_rsp_result, w_rsp_result;
  logic                r_rsp_error, w_rsp_error;
  logic                r_busy, w_busy;
  logic                r_go, w_go;
  logic [W_IN-1:0]     r_fact_in, w_fact_in;

  logic                w_any;
  logic [c_iw-1:0]     w_pick;
  logic [W_IN-1:0]     w_pick_n;
  logic [c_iw:0]       w_sum;

  function automatic logic [NREQ-1:0] f_onehot(input logic [c_iw-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++)
      if (idx == c_iw'(i)) v[i] = 1'b1;
    return v;
  endfunction

  // Walk from rr+NREQ down to rr+1 so the nearest set bit after rr wins last.
  always_comb begin
    w_any    = 1'b0;
    w_pick   = '0;
    w_pick_n = '0;
    w_sum    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_sum = {1'b0, r_rr} + (c_iw+1)'(k);
      if (w_sum >= (c_iw+1)'(NREQ)) w_sum = w_sum - (c_iw+1)'(NREQ);
      if (req[w_sum[c_iw-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[c_iw-1:0];
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (w_pick == c_iw'(i)) w_pick_n = req_n[i*W_IN +: W_IN];
  end

  always_comb begin
    w_state      = r_state;
    w_rr         = r_rr;
    w_owner      = r_owner;
    w_wd         = r_wd;
    w_gnt        = '0;
    w_rsp_valid  = '0;
    w_rsp_result = r_rsp_result;
    w_rsp_error  = r_rsp_error;
    w_go         = r_go;
    w_fact_in    = r_fact_in;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state   = S_ISSUE;
          w_owner   = w_pick;
          w_fact_in = w_pick_n;
          w_go      = 1'b1;
          w_gnt     = f_onehot(w_pick);
        end
      end
      S_ISSUE: begin
        w_wd    = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (fact_done || fact_error) begin
          w_rsp_result = fact_result;
          w_rsp_error  = fact_error;
          w_go         = 1'b0;
          w_rsp_valid  = f_onehot(r_owner);
          w_state      = S_RESP;
        end else if (r_wd == c_wd_last) begin
          w_rsp_result = '0;
          w_rsp_error  = 1'b1;
          w_go         = 1'b0;
          w_rsp_valid  = f_onehot(r_owner);
          w_state      = S_RESP;
        end else begin
          w_wd = r_wd + 1'b1;
        end
      end
      S_RESP: begin
        w_rr    = r_owner;
        w_state = S_DRAIN;
      end
      S_DRAIN: begin
        // Unit must release Done/Error before it can take the next job.
        if (!fact_done && !fact_error) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr         <= c_iw'(NREQ - 1);
      r_owner      <= '0;
      r_wd         <= '0;
      r_gnt        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_error  <= 1'b0;
      r_busy       <= 1'b0;
      r_go         <= 1'b0;
      r_fact_in    <= '0;
    end else begin
      r_state      <= w_state;
      r_rr         <= w_rr;
      r_owner      <= w_owner;
      r_wd         <= w_wd;
      r_gnt        <= w_gnt;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_result <= w_rsp_result;
      r_rsp_error  <= w_rsp_error;
      r_busy       <= w_busy;
      r_go         <= w_go;
      r_fact_in    <= w_fact_in;
    end
  end

  assign gnt        = r_gnt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_error  = r_rsp_error;
  assign busy       = r_busy;
  assign fact_go    = r_go;
  assign fact_in    = r_fact_in;

endmodule
`default_nettype wire

// File: tb/tb_fact_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fact_arbiter : randomized scoreboard bench for fact_arbiter with a
//                   behavioural factorial unit.
// Revision        : 1.0  initial release
// ============================================================================
module tb_fact_arbiter;

  localparam int NREQ = 4, W_IN = 4, W_RES = 32, TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req;
  logic [NREQ*W_IN-1:0] req_n;
  logic [NREQ-1:0]      gnt, rsp_valid;
  logic [W_RES-1:0]     rsp_result;
  logic                 rsp_error, busy, fact_go;
  logic [W_IN-1:0]      fact_in;
  logic                 fact_done, fact_error;
  logic [W_RES-1:0]     fact_result;

  fact_arbiter #(.NREQ(NREQ), .W_IN(W_IN), .W_RES(W_RES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .busy(busy), .fact_go(fact_go), .fact_in(fact_in), .fact_done(fact_done),
    .fact_error(fact_error), .fact_result(fact_result)
  );

  always #5 clk = ~clk;

  logic            req_bit [NREQ];
  logic [W_IN-1:0] opnd    [NREQ];
  always_comb begin
    req   = '0;
    req_n = '0;
    for (int i = 0; i < NREQ; i++) begin
      req[i]                = req_bit[i];
      req_n[i*W_IN +: W_IN] = opnd[i];
    end
  end

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  logic [NREQ-1:0]      snap_req;
  logic [NREQ*W_IN-1:0] snap_n;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    snap_req <= req;
    snap_n   <= req_n;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W_RES-1:0] ref_fact(input logic [W_IN-1:0] n);
    longint unsigned p = 1;
    for (int i = 2; i <= int'(n); i++) p = p * longint'(i);
    return W_RES'(p);
  endfunction

  function automatic logic ref_err(input logic [W_IN-1:0] n);
    return (n == 0) || (n > 12);
  endfunction

  // Unit behaviour: 0 normal, 1 never completes, 2 Done and Error together.
  int unit_mode = 0, lat_lo = 0, lat_hi = 5, hold_hi = 2;
  int t_done = 0;
  initial begin
    int ms, mcnt, mh;
    logic [W_IN-1:0] mn;
    ms = 0; mcnt = 0; mh = 0; mn = '0;
    fact_done = 1'b0; fact_error = 1'b0; fact_result = '0;
    forever begin
      @(negedge clk);
      case (ms)
        0: if (fact_go === 1'b1) begin
             mn = fact_in; mcnt = int'($urandom_range(lat_hi, lat_lo)); ms = 1;
           end
        1: if (fact_go !== 1'b1) ms = 0;
           else if (unit_mode != 1) begin
             if (mcnt == 0) begin
               fact_result = ref_fact(mn);
               fact_error  = (unit_mode == 2) || ref_err(mn);
               fact_done   = (unit_mode == 2) || !ref_err(mn);
               t_done = cyc; mh = int'($urandom_range(hold_hi, 0)); ms = 2;
             end else mcnt--;
           end
        default: if (mh == 0) begin
                   fact_done = 1'b0; fact_error = 1'b0; ms = 0;
                 end else mh--;
      endcase
    end
  end

  typedef struct {
    int               owner;
    logic [W_RES-1:0] res;
    logic             err;
    int               tg;
    int               mode;
  } exp_t;
  exp_t sbq[$];
  int   glog[$];
  int   m_rr = NREQ - 1;

  // Monitor: predicts the winner at each grant, scores each response.
  initial begin
    int own;
    exp_t e;
    logic [W_IN-1:0] n;
    forever begin
      @(negedge clk);
      if (!rst && gnt != '0) begin
        own = -1;
        for (int k = 1; k <= NREQ; k++)
          if (own < 0 && snap_req[(m_rr + k) % NREQ]) own = (m_rr + k) % NREQ;
        if (own < 0) chk("gnt_spurious", 64'(gnt), 64'd0);
        else begin
          n = snap_n[own*W_IN +: W_IN];
          chk("gnt_owner", 64'(gnt), 64'(1 << own));
          chk("go_at_gnt", 64'(fact_go), 64'd1);
          chk("fact_in", 64'(fact_in), 64'(n));
          chk("busy_at_gnt", 64'(busy), 64'd1);
          e.owner = own; e.tg = cyc; e.mode = unit_mode;
          e.res = (unit_mode == 1) ? '0 : ref_fact(n);
          e.err = (unit_mode != 0) || ref_err(n);
          sbq.push_back(e);
          glog.push_back(own);
          m_rr = own;
        end
      end
      if (!rst && rsp_valid != '0) begin
        if (sbq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          e = sbq.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(1 << e.owner));
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_error", 64'(rsp_error), 64'(e.err));
          chk("go_low_at_rsp", 64'(fact_go), 64'd0);
          if (e.mode == 1) chk("timeout_latency", 64'(cyc - e.tg), 64'(TIMEOUT + 1));
          else             chk("rsp_latency", 64'(cyc - t_done), 64'd1);
        end
      end
    end
  end

  task automatic do_req(input int i, input logic [W_IN-1:0] n, input int dly);
    int c;
    repeat (dly) @(posedge clk);
    @(posedge clk); #1;
    opnd[i] = n; req_bit[i] = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (gnt[i]) break;
      c++;
      if (c > 3000) begin chk("gnt_wait_bound", 64'(c), 64'd0); break; end
    end
    req_bit[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin @(negedge clk); c++; end
    while ((busy || sbq.size() != 0) && c < 5000);
    if (c >= 5000) chk("idle_wait_bound", 64'(c), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sbq.delete(); m_rr = NREQ - 1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_fact_go"}, 64'(fact_go), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_fact_in"}, 64'(fact_in), 64'd0);
  endtask

  initial begin
    logic [NREQ-1:0] mask;
    logic [W_IN-1:0] rn [NREQ];
    int rd [NREQ];
    for (int i = 0; i < NREQ; i++) begin req_bit[i] = 1'b0; opnd[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    do_req(0, 4'd5, 0);
    wait_idle();
    chk("single_result", 64'(rsp_result), 64'd120);
    chk("single_busy_after", 64'(busy), 64'd0);

    do_reset();
    glog.delete();
    fork
      do_req(0, 4'd3, 0);
      do_req(1, 4'd4, 0);
      do_req(2, 4'd5, 0);
      do_req(3, 4'd6, 0);
    join
    wait_idle();
    chk("simul_count", 64'(glog.size()), 64'd4);
    for (int k = 0; k < glog.size(); k++) chk("simul_order", 64'(glog[k]), 64'(k));
    chk("simul_last_result", 64'(rsp_result), 64'd720);

    glog.delete();
    fork
      repeat (4) do_req(0, 4'd4, 0);
      repeat (4) do_req(2, 4'd4, 0);
    join
    wait_idle();
    chk("fair_count", 64'(glog.size()), 64'd8);
    for (int k = 1; k < glog.size(); k++) chk("fair_alternate", 64'(glog[k] != glog[k-1]), 64'd1);

    do_req(1, 4'd0, 0);
    wait_idle();
    chk("err_n0_flag", 64'(rsp_error), 64'd1);
    do_req(2, 4'd13, 0);
    wait_idle();
    chk("err_n13_flag", 64'(rsp_error), 64'd1);

    unit_mode = 1;
    do_req(3, 4'd7, 0);
    wait_idle();
    chk("wdog_result", 64'(rsp_result), 64'd0);
    unit_mode = 2;
    do_req(1, 4'd5, 0);
    wait_idle();
    unit_mode = 0;

    lat_lo = 30; lat_hi = 30;
    do_req(1, 4'd10, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midwait_reset");
    sbq.delete(); m_rr = NREQ - 1;
    lat_lo = 0; lat_hi = 5;
    repeat (40) @(negedge clk);
    do_req(1, 4'd3, 0);
    wait_idle();
    chk("post_reset_result", 64'(rsp_result), 64'd6);

    repeat (20) begin
      unit_mode = ($urandom_range(9, 0) == 0) ? 1 : (($urandom_range(3, 0) == 0) ? 2 : 0);
      mask = NREQ'($urandom_range(15, 1));
      for (int i = 0; i < NREQ; i++) begin
        rn[i] = W_IN'($urandom_range(15, 0));
        rd[i] = int'($urandom_range(6, 0));
      end
      fork
        begin if (mask[0]) do_req(0, rn[0], rd[0]); end
        begin if (mask[1]) do_req(1, rn[1], rd[1]); end
        begin if (mask[2]) do_req(2, rn[2], rd[2]); end
        begin if (mask[3]) do_req(3, rn[3], rd[3]); end
      join
      wait_idle();
    end
    unit_mode = 0;
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=%0t required=<500000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
